// File: rtl/alu_shift_pkg.sv
// Shared types for the sequential shift engine.
// States and direction encodings used by alu_shift_seq.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shift_seq_step.sv
// Single-bit shift step: one position toward MSB or LSB.
// Purely combinational; reports the bit pushed off the edge.
import alu_shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o,
  output logic             off_o
);

  always_comb begin
    data_o = data_i;
    off_o  = 1'b0;
    unique case (1'b1)
      (dir_i == DIR_LEFT): begin
        data_o = {data_i[WIDTH-2:0], fill_i};
        off_o  = data_i[WIDTH-1];
      end
      (dir_i == DIR_RIGHT): begin
        data_o = {fill_i, data_i[WIDTH-1:1]};
        off_o  = data_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-bit shift engine built from a one-position step, one step per clock.
// Define ALU_SHIFT_ROTATE_EN to add the in_rot port (rotate instead of fill).
import alu_shift_pkg::*;

module alu_shift_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_fill,
  input  logic [CNT_W-1:0] in_amt,
`ifdef ALU_SHIFT_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_spill
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] spill_q, spill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] step_data;
  logic             step_off;
  logic             step_fill;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

`ifdef ALU_SHIFT_ROTATE_EN
  logic rot_q, rot_d;
  logic edge_bit;

  // Rotate feeds the outgoing bit back in on the same step.
  assign edge_bit  = (dir_q == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];
  assign step_fill = rot_q ? edge_bit : fill_q;
  assign rot_d     = accept ? in_rot : rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rot_q <= 1'b0;
    else        rot_q <= rot_d;
  end
`else
  assign step_fill = fill_q;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .dir_i  (dir_q),
    .fill_i (step_fill),
    .data_o (step_data),
    .off_o  (step_off)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (in_valid)
          state_d = (in_amt == '0) ? DONE : SHIFT;
      SHIFT:
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:
        if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = data_q;
    out_spill = spill_q;
  end

  always_comb begin
    data_d  = data_q;
    spill_d = spill_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    if (accept) begin
      data_d  = in_data;
      spill_d = '0;
      cnt_d   = in_amt;
      dir_d   = in_dir;
      fill_d  = in_fill;
    end else if (state_q == SHIFT) begin
      data_d = step_data;
      cnt_d  = cnt_q - CNT_W'(1);
      if (dir_q == DIR_LEFT)
        spill_d = {spill_q[WIDTH-2:0], step_off};
      else
        spill_d = {step_off, spill_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      spill_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      spill_q <= spill_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with hand-computed vectors.
// Rotate vectors run only when ALU_SHIFT_ROTATE_EN is defined.
module tb_alu_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic       in_fill;
  logic [2:0] in_amt;
  logic       in_rot;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] out_spill;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_fill   (in_fill),
    .in_amt    (in_amt),
`ifdef ALU_SHIFT_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_spill (out_spill)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept one request, count out the steps, check result and handoff.
  task automatic run(input string tag, input logic [3:0] d,
                     input logic dir, input logic fill, input logic rot,
                     input logic [2:0] amt,
                     input logic [3:0] ed, input logic [3:0] es);
    @(negedge clk);
    check({tag, "_rdy"}, {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_fill  = fill;
    in_rot   = rot;
    in_amt   = amt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_dir   = ~dir;
    in_fill  = ~fill;
    in_rot   = ~rot;
    in_amt   = 3'd7;
    for (int k = 1; k <= int'(amt); k++) begin
      check({tag, "_busy"}, {7'd0, out_valid}, 8'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
    check({tag, "_data"}, {4'd0, out_data}, {4'd0, ed});
    check({tag, "_spill"}, {4'd0, out_spill}, {4'd0, es});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, {6'd0, in_ready, out_valid}, 8'b10);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_fill   = 1'b0;
    in_amt    = '0;
    in_rot    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_hs", {6'd0, in_ready, out_valid}, 8'b10);
    check("rst_dat", {out_data, out_spill}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run("l1", 4'b1011, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0110, 4'b0001);
    run("r2", 4'b1011, 1'b1, 1'b1, 1'b0, 3'd2, 4'b1110, 4'b1100);
    run("l6", 4'b1001, 1'b0, 1'b1, 1'b0, 3'd6, 4'b1111, 4'b0111);

    // amt=0 with out_ready held low and a competing request
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'b0101;
    in_dir   = 1'b0;
    in_fill  = 1'b1;
    in_amt   = 3'd0;
    @(posedge clk);
    @(negedge clk);
    in_data = 4'b1111;
    in_amt  = 3'd1;
    for (int c = 0; c < 3; c++) begin
      check("z_ov", {6'd0, in_ready, out_valid}, 8'b01);
      check("z_dat", {out_data, out_spill}, 8'h50);
      @(posedge clk);
      @(negedge clk);
    end
    check("z_hold", {out_data, out_spill}, 8'h50);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("z_idle", {6'd0, in_ready, out_valid}, 8'b10);

    // reset in the middle of an amt=5 request
    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_dir   = 1'b0;
    in_fill  = 1'b1;
    in_amt   = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_hs", {6'd0, in_ready, out_valid}, 8'b10);
    check("mr_dat", {out_data, out_spill}, 8'h00);
    #1;
    rst_n = 1'b1;
    run("pr", 4'b1000, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0000, 4'b0001);

`ifdef ALU_SHIFT_ROTATE_EN
    run("rot", 4'b1001, 1'b0, 1'b0, 1'b1, 3'd1, 4'b0011, 4'b0001);
    run("nrot", 4'b1001, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0010, 4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
